hamming_secded_decoder: RTL and testbench
=========================================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL take parameter R, default 3: Hamming parity-bit count, legal range 3..6.
REQ-002 SHALL take parameter CNT_W, default 16: error-counter width.
REQ-003 SHALL use derived constants N=2^R-1 (Hamming length), K=N-R (data width), CW=N+1 (codeword width).
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  codeword present.
REQ-007 SHALL have port in_ready  out  1  block can accept a codeword.
REQ-008 SHALL have port in_code  in  CW  codeword; bit p = Hamming position p (1..N); bit 0 = overall even parity.
REQ-009 SHALL have port correct_en  in  1  1 = correct single errors; 0 = detect only.
REQ-010 SHALL have port out_valid  out  1  decoded word held.
REQ-011 SHALL have port out_ready  in  1  consumer accepts.
REQ-012 SHALL have port out_data  out  K  data bits.
REQ-013 SHALL have port out_syndrome  out  R  raw syndrome.
REQ-014 SHALL have port out_corr  out  1  single error detected (and fixed if correct_en).
REQ-015 SHALL have port out_uncorr  out  1  double error detected.
REQ-016 SHALL have port cnt_clr  in  1  clear both counters.
REQ-017 SHALL have port cnt_corr  out  CNT_W  saturating count of single errors.
REQ-018 SHALL have port cnt_uncorr  out  CNT_W  saturating count of double errors.

Function
REQ-019 SHALL compute syndrome = XOR of indices p (1..N) with in_code[p]=1; overall parity fail = XOR of all CW bits.
REQ-020 SHALL classify each codeword as follows: syndrome 0 with parity ok = clean; syndrome !=0 with parity fail = single error at position syndrome; syndrome 0 with parity fail = single error in bit 0; syndrome !=0 with parity ok = double error.
REQ-021 SHALL, when correct_en=1 and the error is single, invert position syndrome before extraction (bit-0 error: data unchanged).
REQ-022 SHALL, for double errors or correct_en=0, output uncorrected data bits.
REQ-023 SHALL extract data from non-power-of-two positions in ascending order; out_data[0] = position 3.
REQ-024 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-025 SHALL accept a codeword when in_valid && in_ready and register the result; latency 1 cycle, throughput 1 word/cycle.
REQ-026 SHALL hold out_data, out_syndrome, out_corr and out_uncorr stable while out_valid && !out_ready.
REQ-027 SHALL clear out_valid after out_ready with no new accept; on simultaneous output and input handshakes, load the new word with out_valid staying 1.
REQ-028 SHALL increment cnt_corr or cnt_uncorr on input acceptance of the matching class, independent of correct_en.
REQ-029 SHALL saturate counters at all-ones with no wrap.
REQ-030 SHALL give cnt_clr priority: a concurrent event is lost and the counter reads 0 next cycle.

Reset
REQ-031 SHALL, on reset, set out_valid=0 and out_data, out_syndrome, out_corr, out_uncorr, cnt_corr and cnt_uncorr to 0; in_ready=1 in the following cycle.
REQ-032 SHALL discard a held, unconsumed word when reset is asserted mid-operation; no counter update for a word presented during reset.

Structure
REQ-033 SHALL place R-dependent constants (N, K, CW) and the is_pow2 and data-position mapping functions in package hamming_pkg, shared with the encoder.
REQ-034 SHALL implement each counter as sub-module ecc_sat_counter (parameter W; inputs clk, reset, clr, inc; output count), instantiated twice.

Verification
REQ-035 SHALL verify, with R=3: in_code=8'hAA -> out_data=4'b1011, syndrome 0, corr 0, uncorr 0.
REQ-036 SHALL verify: 8'h8A (position 5 flipped), correct_en=1 -> out_data=4'b1011, syndrome 5, corr 1, cnt_corr+1; with correct_en=0 -> out_data=4'b1001, corr 1.
REQ-037 SHALL verify: 8'hAB (bit 0 flipped) -> out_data=4'b1011, syndrome 0, corr 1.
REQ-038 SHALL verify: 8'hCA (positions 5 and 6 flipped) -> syndrome 3, uncorr 1, out_data=4'b1101, cnt_uncorr+1.
REQ-039 SHALL verify: out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no counter change; then back-to-back words with out_ready=1 -> one output per cycle.
REQ-040 SHALL verify, with CNT_W=2: 4 single errors -> cnt_corr=3 (saturated); cnt_clr asserted with a single error in the same cycle -> cnt_corr=0; reset with out_valid=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared constants and helpers for the Hamming SECDED encoder/decoder pair.
// A package cannot be parameterised, so the R-dependent sizes are provided as
// constant functions that the modules evaluate into their own localparams.
//   hamming_n(r)  : Hamming length N = 2^r - 1
//   hamming_k(r)  : data width K = N - r
//   hamming_cw(r) : codeword width CW = N + 1 (bit 0 = overall parity)
//   is_pow2(p)    : true for parity positions 1, 2, 4, ...
//   data_pos(i)   : Hamming position carrying data bit i (ascending order)
// -----------------------------------------------------------------------------
package hamming_pkg;

   localparam int R_MIN = 3;
   localparam int R_MAX = 6;

   // Decode outcome of one codeword.
   typedef enum logic [1:0] {
      CLS_CLEAN  = 2'd0,  // syndrome 0, parity ok
      CLS_SINGLE = 2'd1,  // syndrome != 0, parity fail: error at position syndrome
      CLS_BIT0   = 2'd2,  // syndrome 0, parity fail: overall parity bit flipped
      CLS_DOUBLE = 2'd3   // syndrome != 0, parity ok: uncorrectable
   } ecc_class_e;

   function automatic int hamming_n(input int r);
      return (1 << r) - 1;
   endfunction

   function automatic int hamming_k(input int r);
      return hamming_n(r) - r;
   endfunction

   function automatic int hamming_cw(input int r);
      return hamming_n(r) + 1;
   endfunction

   function automatic bit is_pow2(input int p);
      return (p > 0) && ((p & (p - 1)) == 0);
   endfunction

   // Positions up to 2^R_MAX - 1 are scanned; the caller only asks for i < K.
   function automatic int data_pos(input int i);
      int pos;
      int cnt;
      pos = 0;
      cnt = 0;
      for (int p = 1; p < (1 << R_MAX); p++) begin
         if (!is_pow2(p)) begin
            if (cnt == i) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder_if
// Codeword-in / decoded-word-out valid/ready bus of the SECDED decoder.
//   in_valid, in_ready, in_code, correct_en  : input side
//   out_valid, out_ready, out_data,
//   out_syndrome, out_corr, out_uncorr       : output side
// modport master : the environment (drives codewords, consumes results)
// modport slave  : the decoder
// -----------------------------------------------------------------------------
interface hamming_secded_decoder_if
   import hamming_pkg::*;
#(
   parameter int R = 3
);

   localparam int K  = hamming_k(R);
   localparam int CW = hamming_cw(R);

   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_code;
   logic          correct_en;
   logic          out_valid;
   logic          out_ready;
   logic [K-1:0]  out_data;
   logic [R-1:0]  out_syndrome;
   logic          out_corr;
   logic          out_uncorr;

   modport master (
      output in_valid, in_code, correct_en, out_ready,
      input  in_ready, out_valid, out_data, out_syndrome, out_corr, out_uncorr
   );

   modport slave (
      input  in_valid, in_code, correct_en, out_ready,
      output in_ready, out_valid, out_data, out_syndrome, out_corr, out_uncorr
   );

endinterface

// File: rtl/ecc_sat_counter.sv
// -----------------------------------------------------------------------------
// ecc_sat_counter
// Saturating event counter; clear wins over a concurrent increment.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   clr   : synchronous clear
//   inc   : count one event
//   count : current value, sticks at all-ones
// -----------------------------------------------------------------------------
module ecc_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values, whatever order the simulator runs the blocks.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder
// Single-error-correct / double-error-detect decoder with a one-entry output
// register (latency 1, throughput 1 word/cycle) and saturating error counters.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   bus        : codeword in / decoded word out (valid/ready), slave side
//   cnt_clr    : clear both counters (wins over a same-cycle event)
//   cnt_corr   : number of accepted single-error words
//   cnt_uncorr : number of accepted double-error words
// -----------------------------------------------------------------------------
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int R     = 3,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   hamming_secded_decoder_if.slave bus,
   input  logic                    cnt_clr,
   output logic [CNT_W-1:0]        cnt_corr,
   output logic [CNT_W-1:0]        cnt_uncorr
);

   localparam int N = hamming_n(R);
   localparam int K = hamming_k(R);

   logic [R-1:0] syndrome;
   logic         parity_fail;
   ecc_class_e   cls;
   logic         flip_en;
   logic [K-1:0] data_next;
   logic         accept;

   logic         out_valid_q;
   logic [K-1:0] out_data_q;
   logic [R-1:0] out_syndrome_q;
   logic         out_corr_q;
   logic         out_uncorr_q;

   // ---------------------------------------------------------------------------
   // Decode: syndrome, classification, optional correction, data extraction.
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a value at the top of the block so no path
   // leaves one unassigned; that is what keeps this logic free of latches.
   always_comb begin
      syndrome    = '0;
      parity_fail = ^bus.in_code;
      cls         = CLS_CLEAN;
      flip_en     = 1'b0;
      data_next   = '0;

      for (int p = 1; p <= N; p++) begin
         if (bus.in_code[p]) syndrome = syndrome ^ R'(p);
      end

      unique case ({syndrome != '0, parity_fail})
         2'b00: cls = CLS_CLEAN;
         2'b01: cls = CLS_BIT0;
         2'b11: cls = CLS_SINGLE;
         2'b10: cls = CLS_DOUBLE;
         default: cls = CLS_CLEAN;
      endcase

      // A bit-0 error needs no data fix; only a located single error flips.
      flip_en = bus.correct_en && (cls == CLS_SINGLE);

      for (int i = 0; i < K; i++) begin
         data_next[i] = bus.in_code[data_pos(i)]
                        ^ (flip_en && (syndrome == R'(data_pos(i))));
      end
   end

   // ---------------------------------------------------------------------------
   // Output register with valid/ready handshake.
   // ---------------------------------------------------------------------------
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // NOTE: the payload registers are reset too, so the outputs read as zero
   // after reset rather than whatever word was last held.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_syndrome_q <= '0;
         out_corr_q     <= 1'b0;
         out_uncorr_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q    <= 1'b1;
         out_data_q     <= data_next;
         out_syndrome_q <= syndrome;
         out_corr_q     <= (cls == CLS_SINGLE) || (cls == CLS_BIT0);
         out_uncorr_q   <= (cls == CLS_DOUBLE);
      end else if (bus.out_ready) begin
         out_valid_q    <= 1'b0;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_syndrome = out_syndrome_q;
   assign bus.out_corr     = out_corr_q;
   assign bus.out_uncorr   = out_uncorr_q;

   // ---------------------------------------------------------------------------
   // Error statistics: counted on acceptance, regardless of correct_en.
   // ---------------------------------------------------------------------------
   ecc_sat_counter #(.W(CNT_W)) u_cnt_corr (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (accept && ((cls == CLS_SINGLE) || (cls == CLS_BIT0))),
      .count (cnt_corr)
   );

   ecc_sat_counter #(.W(CNT_W)) u_cnt_uncorr (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (accept && (cls == CLS_DOUBLE)),
      .count (cnt_uncorr)
   );

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_decoder
// Directed bench for the SECDED decoder at R=3 with 2-bit counters: a vector
// table for the decode function plus hand-written backpressure, saturation,
// clear-priority and reset sequences.
// -----------------------------------------------------------------------------
module tb_hamming_secded_decoder;

   localparam int R     = 3;
   localparam int CNT_W = 2;
   localparam int K     = 4;
   localparam int CW    = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_corr;
   logic [CNT_W-1:0] cnt_uncorr;

   always #5 clk = ~clk;

   hamming_secded_decoder_if #(.R(R)) bus ();

   hamming_secded_decoder #(.R(R), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .cnt_clr    (cnt_clr),
      .cnt_corr   (cnt_corr),
      .cnt_uncorr (cnt_uncorr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance past a rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [CW-1:0] code;
      logic          corr_en;
      logic [K-1:0]  data;
      logic [R-1:0]  syn;
      logic          corr;
      logic          uncorr;
   } vec_t;

   vec_t vecs[8];
   int   exp_cc;
   int   exp_cu;

   task automatic check_word(input string tag, input logic [K-1:0] data, input logic [R-1:0] syn,
                             input logic corr, input logic uncorr);
      check({tag, " out_valid"},    32'(bus.out_valid),    32'd1);
      check({tag, " out_data"},     32'(bus.out_data),     32'(data));
      check({tag, " out_syndrome"}, 32'(bus.out_syndrome), 32'(syn));
      check({tag, " out_corr"},     32'(bus.out_corr),     32'(corr));
      check({tag, " out_uncorr"},   32'(bus.out_uncorr),   32'(uncorr));
   endtask

   initial begin
      //               code    en  data     syn   corr uncorr
      vecs[0] = '{8'hAA, 1'b1, 4'b1011, 3'd0, 1'b0, 1'b0};  // clean
      vecs[1] = '{8'h8A, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0};  // pos 5, corrected
      vecs[2] = '{8'h8A, 1'b0, 4'b1001, 3'd5, 1'b1, 1'b0};  // pos 5, detect only
      vecs[3] = '{8'hAB, 1'b1, 4'b1011, 3'd0, 1'b1, 1'b0};  // bit 0 flipped
      vecs[4] = '{8'hCA, 1'b1, 4'b1101, 3'd3, 1'b0, 1'b1};  // pos 5+6, double
      vecs[5] = '{8'hCA, 1'b0, 4'b1101, 3'd3, 1'b0, 1'b1};  // double, detect only
      vecs[6] = '{8'hAB, 1'b0, 4'b1011, 3'd0, 1'b1, 1'b0};  // 4th single: saturates
      vecs[7] = '{8'h55, 1'b1, 4'b0100, 3'd0, 1'b0, 1'b0};  // clean, other pattern

      // ---------------- reset state ----------------
      reset          = 1'b1;
      cnt_clr        = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_code    = '0;
      bus.correct_en = 1'b0;
      bus.out_ready  = 1'b0;
      tick();
      tick();
      check("reset out_valid",  32'(bus.out_valid),  32'd0);
      check("reset out_data",   32'(bus.out_data),   32'd0);
      check("reset out_corr",   32'(bus.out_corr),   32'd0);
      check("reset out_uncorr", 32'(bus.out_uncorr), 32'd0);
      check("reset cnt_corr",   32'(cnt_corr),       32'd0);
      check("reset cnt_uncorr", 32'(cnt_uncorr),     32'd0);
      check("reset in_ready",   32'(bus.in_ready),   32'd1);
      reset = 1'b0;

      // ---------------- table-driven decode ----------------
      exp_cc = 0;
      exp_cu = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid   = 1'b1;
         bus.in_code    = vecs[i].code;
         bus.correct_en = vecs[i].corr_en;
         tick();
         if (vecs[i].corr   && exp_cc < CNT_MAX) exp_cc++;
         if (vecs[i].uncorr && exp_cu < CNT_MAX) exp_cu++;
         check_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].syn, vecs[i].corr, vecs[i].uncorr);
         check($sformatf("vec%0d cnt_corr", i),   32'(cnt_corr),   32'(exp_cc));
         check($sformatf("vec%0d cnt_uncorr", i), 32'(cnt_uncorr), 32'(exp_cu));
      end

      // ---------------- backpressure then back-to-back ----------------
      bus.in_valid = 1'b0;
      cnt_clr      = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("drain out_valid",  32'(bus.out_valid), 32'd0);
      check("clr cnt_corr",     32'(cnt_corr),      32'd0);
      check("clr cnt_uncorr",   32'(cnt_uncorr),    32'd0);

      bus.in_valid   = 1'b1;
      bus.in_code    = 8'h8A;
      bus.correct_en = 1'b1;
      bus.out_ready  = 1'b0;
      tick();
      check_word("stall load", 4'b1011, 3'd5, 1'b1, 1'b0);
      check("stall load cnt_corr", 32'(cnt_corr), 32'd1);
      bus.in_code = 8'hCA;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("stall%0d in_ready", c), 32'(bus.in_ready), 32'd0);
         tick();
         check_word($sformatf("stall%0d", c), 4'b1011, 3'd5, 1'b1, 1'b0);
         check($sformatf("stall%0d cnt_corr", c),   32'(cnt_corr),   32'd1);
         check($sformatf("stall%0d cnt_uncorr", c), 32'(cnt_uncorr), 32'd0);
      end

      bus.out_ready = 1'b1;
      bus.in_code   = 8'hAA;
      #1;
      check("b2b in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_word("b2b0", 4'b1011, 3'd0, 1'b0, 1'b0);
      bus.in_code = 8'hCA;
      tick();
      check_word("b2b1", 4'b1101, 3'd3, 1'b0, 1'b1);
      check("b2b1 cnt_uncorr", 32'(cnt_uncorr), 32'd1);
      bus.in_code = 8'hAB;
      tick();
      check_word("b2b2", 4'b1011, 3'd0, 1'b1, 1'b0);
      check("b2b2 cnt_corr", 32'(cnt_corr), 32'd2);
      bus.in_valid = 1'b0;
      tick();
      check("b2b drain out_valid", 32'(bus.out_valid), 32'd0);

      // ---------------- saturation and clear priority ----------------
      cnt_clr = 1'b1;
      tick();
      cnt_clr      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_code  = 8'h8A;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("sat%0d cnt_corr", k), 32'(cnt_corr), 32'((k < CNT_MAX) ? k : CNT_MAX));
      end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr+event cnt_corr",  32'(cnt_corr),      32'd0);
      check("clr+event out_valid", 32'(bus.out_valid), 32'd1);

      // ---------------- reset while holding a word ----------------
      bus.out_ready = 1'b0;
      bus.in_code   = 8'hCA;
      reset         = 1'b1;
      tick();
      check("midreset out_valid",  32'(bus.out_valid), 32'd0);
      check("midreset out_data",   32'(bus.out_data),  32'd0);
      check("midreset in_ready",   32'(bus.in_ready),  32'd1);
      check("midreset cnt_uncorr", 32'(cnt_uncorr),    32'd0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check("post reset out_valid",  32'(bus.out_valid), 32'd0);
      check("post reset cnt_uncorr", 32'(cnt_uncorr),    32'd0);
      check("post reset cnt_corr",   32'(cnt_corr),      32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
